led_matrix_rx: RTL and testbench
================================

LED_MATRIX_RX -- requirements
Module: led_matrix_rx

Interface
REQ-001 Parameter COLS, default 8: number of matrix columns, which is also the column shift-chain length.
REQ-002 Parameter ROWS, default 8: number of matrix rows, which is also the row shift-chain length; a power of two.
REQ-003 clk  input  1: single clock for all state; the block SHALL use one clock.
REQ-004 reset  input  1: reset is synchronous and active-high.
REQ-005 cclk  input  1: column shift clock, asynchronous to clk.
REQ-006 csdi  input  1: column serial data.
REQ-007 le  input  1: latch enable; a rising edge commits one row.
REQ-008 rclk  input  1: row shift clock.
REQ-009 rsdi  input  1: row serial data.
REQ-010 oeb  input  1: output enable, active-low.
REQ-011 rd_row  input  $clog2(ROWS): frame buffer read index.
REQ-012 rd_data  output  COLS: frame buffer row at rd_row, combinational from registers.
REQ-013 frame_done  output  1: one-cycle pulse when a complete frame has been captured.
REQ-014 frame_cnt  output  8: count of completed frames, wrapping.
REQ-015 err_cnt  output  8: count of malformed commits, saturating.

Function
REQ-016 cclk, csdi, le, rclk, rsdi and oeb SHALL each pass through a 2-FF synchronizer.
REQ-017 cclk, le and rclk SHALL have a previous-value register; a rising edge is detected when the synced value is 1 and the previous value is 0.
REQ-018 On a cclk rising edge, col_shift SHALL become {col_shift[COLS-2:0], synced csdi}, so the first bit shifted in ends at the MSB after COLS shifts.
REQ-019 On an rclk rising edge, row_shift SHALL become {row_shift[ROWS-2:0], synced rsdi}.
REQ-020 On an le rising edge (a commit), the block SHALL use the col_shift and row_shift values held before any shift occurring in the same cycle.
REQ-021 Commit with synced oeb=1 SHALL be ignored: no write, no error count.
REQ-022 Commit with oeb=0 and row_shift one-hot at bit k SHALL write col_shift into frame[k] and set row_valid[k].
REQ-023 Commit with oeb=0 and row_shift zero or multi-hot SHALL increment err_cnt, saturating at 255, and SHALL leave the frame and row_valid unchanged.
REQ-024 When a write makes row_valid all ones, the next cycle SHALL see frame_done=1 for one cycle, row_valid cleared, and frame_cnt incremented mod 256.
REQ-025 Rewriting an already-valid row SHALL overwrite frame[k], leave row_valid unchanged, and SHALL NOT raise an error.
REQ-026 End-to-end latency: a pin transition first sampled at clk edge N SHALL affect shift or frame state at clk edge N+3.
REQ-027 rd_data SHALL equal frame[rd_row] in the same cycle, including a row written at that edge once it is registered.
REQ-028 frame_done SHALL pulse at most once per frame; back-to-back frames SHALL each pulse.

Reset
REQ-029 Under reset, the following SHALL be cleared to 0: col_shift, row_shift, all frame rows, row_valid, frame_done, frame_cnt and err_cnt.
REQ-030 Under reset, synchronizer stages and edge-previous registers SHALL load 1, so no spurious rising edge appears on release regardless of pin level.
REQ-031 Reset asserted mid-frame SHALL discard partial shifts and row_valid; the first post-reset frame SHALL need all ROWS rows again.
REQ-032 Reset SHALL take priority over every same-cycle event.

Verification
REQ-033 Shift csdi 8'hA5 MSB-first, row one-hot 8'h01, oeb=0, pulse le -> frame[0]=8'hA5, row_valid=8'h01, frame_done stays 0, err_cnt=0.
REQ-034 Eight commits with rows 0..7 and data 8'h00..8'h07 -> single frame_done pulse, frame_cnt=1, rd_row=5 gives rd_data=8'h05, row_valid=0.
REQ-035 Commit with row_shift=8'h03 and then 8'h00, oeb=0 -> err_cnt=2, frame unchanged; 300 bad commits -> err_cnt=255.
REQ-036 Valid commit with oeb=1 -> no write, err_cnt unchanged; a cclk and le rising edge in the same cycle -> the latched row excludes the new bit.
REQ-037 Reset after 4 valid rows, with le held high through reset release -> no commit; then 8 valid rows give exactly one frame_done and frame_cnt=1.
REQ-038 256 complete frames -> frame_cnt wraps to 0 with 256 frame_done pulses.

Source files
------------

// File: rtl/led_matrix_rx.sv
// Serial LED-matrix receiver: column/row shift chains clocked by synchronized pin edges,
// committed into a frame buffer on latch-enable rising edges, with frame and error counters.
module led_matrix_rx #(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cclk,
    input  logic                     csdi,
    input  logic                     le,
    input  logic                     rclk,
    input  logic                     rsdi,
    input  logic                     oeb,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [COLS-1:0]          rd_data,
    output logic                     frame_done,
    output logic [7:0]               frame_cnt,
    output logic [7:0]               err_cnt
);

    localparam int RW = $clog2(ROWS);

    // Bit positions of each pin in the synchronizer vectors.
    localparam int P_CCLK = 0;
    localparam int P_CSDI = 1;
    localparam int P_LE   = 2;
    localparam int P_RCLK = 3;
    localparam int P_RSDI = 4;
    localparam int P_OEB  = 5;

    logic [5:0]       pins;
    logic [5:0]       sync1;
    logic [5:0]       sync2;
    logic [2:0]       prev;        // {rclk, le, cclk} one cycle behind sync2

    // Registered edge strobes and the data/enable sampled alongside them.
    logic             cclk_rise;
    logic             le_rise;
    logic             rclk_rise;
    logic             csdi_q;
    logic             rsdi_q;
    logic             oeb_q;

    logic [COLS-1:0]  col_shift;
    logic [ROWS-1:0]  row_shift;
    logic [ROWS-1:0]  row_valid;
    logic [COLS-1:0]  frame [ROWS];

    logic             row_onehot;
    logic [RW-1:0]    row_idx;

    assign pins = {oeb, rsdi, rclk, le, csdi, cclk};

    always_comb begin
        row_onehot = 1'b0;
        row_idx    = '0;
        if (row_shift != '0 && (row_shift & (row_shift - 1'b1)) == '0)
            row_onehot = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            if (row_shift[i])
                row_idx = RW'(i);
        end
    end

    assign rd_data = frame[rd_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync and edge history load high so a pin already high on release is not an edge.
            sync1      <= '1;
            sync2      <= '1;
            prev       <= '1;
            cclk_rise  <= 1'b0;
            le_rise    <= 1'b0;
            rclk_rise  <= 1'b0;
            csdi_q     <= 1'b1;
            rsdi_q     <= 1'b1;
            oeb_q      <= 1'b1;
            col_shift  <= '0;
            row_shift  <= '0;
            row_valid  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            for (int i = 0; i < ROWS; i++)
                frame[i] <= '0;
        end else begin
            sync1     <= pins;
            sync2     <= sync1;
            prev      <= {sync2[P_RCLK], sync2[P_LE], sync2[P_CCLK]};
            cclk_rise <= sync2[P_CCLK] & ~prev[0];
            le_rise   <= sync2[P_LE]   & ~prev[1];
            rclk_rise <= sync2[P_RCLK] & ~prev[2];
            csdi_q    <= sync2[P_CSDI];
            rsdi_q    <= sync2[P_RSDI];
            oeb_q     <= sync2[P_OEB];

            frame_done <= 1'b0;

            // Commit reads the chains as they stood before this cycle's shifts.
            if (le_rise && !oeb_q) begin
                if (row_onehot) begin
                    frame[row_idx] <= col_shift;
                    if (&(row_valid | row_shift)) begin
                        row_valid  <= '0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end else begin
                        row_valid <= row_valid | row_shift;
                    end
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end

            if (cclk_rise)
                col_shift <= {col_shift[COLS-2:0], csdi_q};
            if (rclk_rise)
                row_shift <= {row_shift[ROWS-2:0], rsdi_q};
        end
    end

endmodule

// File: tb/tb_led_matrix_rx.sv
// Randomized and directed bench for led_matrix_rx against a behavioural frame-buffer model.
module tb_led_matrix_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cclk = 1'b0, csdi = 1'b0, le = 1'b0, rclk = 1'b0, rsdi = 1'b0, oeb = 1'b0;
    logic [2:0] rd_row = '0;
    logic [7:0] rd_data;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    led_matrix_rx #(.COLS(8), .ROWS(8)) dut (
        .clk(clk), .reset(reset), .cclk(cclk), .csdi(csdi), .le(le),
        .rclk(rclk), .rsdi(rsdi), .oeb(oeb), .rd_row(rd_row),
        .rd_data(rd_data), .frame_done(frame_done), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: a pin level sampled at edge M acts on state at edge M+3.
    // h[0] is the sample at the current edge, h[4] four edges ago; reset makes all history read high.
    logic [5:0] h [5];
    logic [7:0] m_col, m_row, m_rv, m_fcnt, m_err;
    logic [7:0] m_frame [8];
    logic       m_done;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) h[i] = 6'h3F;
            for (int i = 0; i < 8; i++) m_frame[i] = 8'h00;
            m_col = 0; m_row = 0; m_rv = 0; m_done = 0; m_fcnt = 0; m_err = 0;
        end else begin
            for (int i = 4; i > 0; i--) h[i] = h[i-1];
            h[0] = {oeb, rsdi, rclk, le, csdi, cclk};
            m_done = 1'b0;
            if (h[3][2] && !h[4][2] && !h[3][5]) begin
                if ($countones(m_row) == 1) begin
                    m_frame[$clog2(m_row)] = m_col;
                    m_rv = m_rv | m_row;
                    if (m_rv == 8'hFF) begin
                        m_rv = 0;
                        m_done = 1'b1;
                        m_fcnt = m_fcnt + 8'd1;
                    end
                end else if (m_err != 8'd255) begin
                    m_err = m_err + 8'd1;
                end
            end
            if (h[3][0] && !h[4][0]) m_col = {m_col[6:0], h[3][1]};
            if (h[3][3] && !h[4][3]) m_row = {m_row[6:0], h[3][4]};
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("rd_data",    rd_data,       m_frame[rd_row]);
            check("frame_done", frame_done,    m_done);
            check("frame_cnt",  frame_cnt,     m_fcnt);
            check("err_cnt",    err_cnt,       m_err);
            check("row_valid",  dut.row_valid, m_rv);
            if (frame_done) done_seen++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; tick(n); reset = 1'b0; tick(1);
    endtask

    task automatic pulse_cclk(input logic d);
        csdi = d; cclk = 1'b1; tick(1); cclk = 1'b0; tick(1);
    endtask

    task automatic pulse_rclk(input logic d);
        rsdi = d; rclk = 1'b1; tick(1); rclk = 1'b0; tick(1);
    endtask

    task automatic pulse_le();
        le = 1'b1; tick(1); le = 1'b0; tick(1);
    endtask

    task automatic load_col(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) pulse_cclk(v[i]);
    endtask

    task automatic load_row(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) pulse_rclk(v[i]);
    endtask

    int d0;

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        check("reset_frame_cnt", frame_cnt, 8'd0);
        check("reset_err_cnt",   err_cnt,   8'd0);

        // Single row A5 into row 0.
        oeb = 1'b0;
        load_col(8'hA5); load_row(8'h01); pulse_le(); tick(5);
        rd_row = 3'd0; tick(1);
        check("a5_row0", rd_data, 8'hA5);
        check("a5_rv", dut.row_valid, 8'h01);
        check("a5_err", err_cnt, 8'd0);

        // Full frame with data equal to row index.
        do_reset(2);
        d0 = done_seen;
        for (int r = 0; r < 8; r++) begin
            load_col(8'(r)); load_row(8'(1 << r)); pulse_le();
        end
        tick(6);
        rd_row = 3'd5; tick(1);
        check("frame_rd5", rd_data, 8'h05);
        check("frame_cnt1", frame_cnt, 8'd1);
        check("frame_pulses", done_seen - d0, 1);
        check("frame_rv0", dut.row_valid, 8'h00);

        // Malformed rows and saturation.
        do_reset(2);
        load_col(8'h5A);
        load_row(8'h03); pulse_le();
        load_row(8'h00); pulse_le();
        tick(5);
        rd_row = 3'd0; tick(1);
        check("err_two", err_cnt, 8'd2);
        check("err_frame0", rd_data, 8'h00);
        for (int i = 0; i < 300; i++) pulse_le();
        tick(5);
        check("err_sat", err_cnt, 8'd255);

        // oeb high blocks the commit; cclk and le together latch the old column.
        do_reset(2);
        load_col(8'h3C); load_row(8'h04);
        oeb = 1'b1; pulse_le(); tick(5); oeb = 1'b0; tick(4);
        rd_row = 3'd2; tick(1);
        check("oeb_nowrite", rd_data, 8'h00);
        check("oeb_noerr", err_cnt, 8'd0);
        csdi = 1'b1; cclk = 1'b1; le = 1'b1; tick(1);
        cclk = 1'b0; le = 1'b0; tick(6);
        check("same_cycle_old_col", rd_data, 8'h3C);
        check("same_cycle_shift", dut.col_shift, 8'h79);

        // Reset mid-frame with le held high across release.
        do_reset(2);
        for (int r = 0; r < 4; r++) begin
            load_col(8'hC0 + 8'(r)); load_row(8'(1 << r)); pulse_le();
        end
        le = 1'b1; reset = 1'b1; tick(3); reset = 1'b0; tick(8); le = 1'b0; tick(2);
        check("rst_le_noerr", err_cnt, 8'd0);
        d0 = done_seen;
        for (int r = 0; r < 8; r++) begin
            pulse_rclk(r == 0); pulse_le();
        end
        tick(6);
        check("rst_frame_pulses", done_seen - d0, 1);
        check("rst_frame_cnt", frame_cnt, 8'd1);

        // 256 frames wrap the frame counter.
        do_reset(2);
        load_col(8'h81);
        d0 = done_seen;
        for (int f = 0; f < 256; f++)
            for (int r = 0; r < 8; r++) begin
                pulse_rclk(r == 0); pulse_le();
            end
        tick(6);
        check("wrap_pulses", done_seen - d0, 256);
        check("wrap_cnt", frame_cnt, 8'd0);

        // Random pin activity, including occasional mid-stream resets.
        do_reset(2);
        for (int c = 0; c < 6000; c++) begin
            cclk   = 1'($urandom_range(0, 1));
            csdi   = 1'($urandom_range(0, 1));
            le     = ($urandom_range(0, 3) == 0);
            rclk   = 1'($urandom_range(0, 1));
            rsdi   = ($urandom_range(0, 5) == 0);
            oeb    = ($urandom_range(0, 4) == 0);
            rd_row = 3'($urandom_range(0, 7));
            reset  = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
